// File: rtl/fetch_pkg.sv
// Shared encodings for the fetch/PC unit: next-PC selects from the control decoder and FSM states.
package fetch_pkg;

    localparam logic [2:0] NPC_SEQ = 3'b000;
    localparam logic [2:0] NPC_BEQ = 3'b001;
    localparam logic [2:0] NPC_J   = 3'b010;
    localparam logic [2:0] NPC_BNE = 3'b011;
    localparam logic [2:0] NPC_JR  = 3'b100;

    typedef enum logic [1:0] {
        ST_RST  = 2'b00,
        ST_REQ  = 2'b01,
        ST_EXEC = 2'b10,
        ST_HALT = 2'b11
    } state_t;

endpackage

// File: rtl/npc_calc.sv
// Combinational next-PC selection for sequential, branch, jump and jump-register flow.
module npc_calc
    import fetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [25:0] instr,
    input  logic [2:0]  npc_op,
    input  logic        zero,
    input  logic [31:0] rs_data,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    logic [31:0] pc4;
    logic [31:0] br_off;
    logic [31:0] br_target;
    logic [31:0] j_target;

    // All adds are 32-bit modulo; wrap-around is intentional and unflagged.
    assign pc4       = pc + 32'd4;
    assign br_off    = {{14{instr[15]}}, instr[15:0], 2'b00};
    assign br_target = pc4 + br_off;
    assign j_target  = {pc4[31:28], instr[25:0], 2'b00};

    always_comb begin
        next_pc = pc4;
        case (npc_op)
            NPC_BEQ: next_pc = zero ? br_target : pc4;
            NPC_BNE: next_pc = zero ? pc4 : br_target;
            NPC_J:   next_pc = j_target;
            NPC_JR:  next_pc = rs_data;
            default: next_pc = pc4;
        endcase
    end

    // Branch and jump targets are word-aligned by construction; only a register target can be bad.
    assign misaligned = (npc_op == NPC_JR) && (rs_data[1:0] != 2'b00);

endmodule

// File: rtl/fetch_pc_unit.sv
// Program counter, instruction fetch over a req/ack handshake, and instruction register for the MIPS core.
module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  op,
    output logic [5:0]  func,
    output logic        instr_valid,
    input  logic        commit,
    input  logic [2:0]  npc_op,
    input  logic        zero,
    input  logic [31:0] rs_data,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        addr_err
);

    state_t      state_reg;
    state_t      state_next;
    logic [31:0] pc_reg;
    logic [31:0] instr_reg;
    logic        addr_err_reg;
    logic [31:0] next_pc;
    logic        misaligned;

    npc_calc u_npc_calc (
        .pc         (pc_reg),
        .instr      (instr_reg[25:0]),
        .npc_op     (npc_op),
        .zero       (zero),
        .rs_data    (rs_data),
        .next_pc    (next_pc),
        .misaligned (misaligned)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_RST;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_RST:  state_next = ST_REQ;
            ST_REQ:  if (imem_ack) state_next = ST_EXEC;
            ST_EXEC: if (commit) state_next = misaligned ? ST_HALT : ST_REQ;
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_RST;
        endcase
    end

    // Request and valid decode straight from state so an async reset drops them immediately.
    always_comb begin
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        case (state_reg)
            ST_REQ:  imem_req    = 1'b1;
            ST_EXEC: instr_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg       <= RESET_PC;
            instr_reg    <= 32'd0;
            addr_err_reg <= 1'b0;
        end else begin
            if (state_reg == ST_REQ && imem_ack) begin
                instr_reg <= imem_rdata;
            end
            // A misaligned jr leaves pc at the faulting instruction for post-mortem inspection.
            if (state_reg == ST_EXEC && commit) begin
                if (misaligned) begin
                    addr_err_reg <= 1'b1;
                end else begin
                    pc_reg <= next_pc;
                end
            end
        end
    end

    assign imem_addr = pc_reg;
    assign instr     = instr_reg;
    assign op        = instr_reg[31:26];
    assign func      = instr_reg[5:0];
    assign pc        = pc_reg;
    assign pc_plus4  = pc_reg + 32'd4;
    assign addr_err  = addr_err_reg;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: drives on the falling edge, checks on the next falling edge.
module tb_fetch_pc_unit;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [5:0]  op;
    logic [5:0]  func;
    logic        instr_valid;
    logic        commit;
    logic [2:0]  npc_op;
    logic        zero;
    logic [31:0] rs_data;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        addr_err;

    int tests_run;
    int tests_failed;

    fetch_pc_unit #(.RESET_PC(32'h0000_3000)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .op          (op),
        .func        (func),
        .instr_valid (instr_valid),
        .commit      (commit),
        .npc_op      (npc_op),
        .zero        (zero),
        .rs_data     (rs_data),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .addr_err    (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: 0x%08h", tag, got);
        end
    endtask

    // Waits (bounded) for a request, checks the address, answers after ack_delay idle cycles.
    task automatic fetch(input logic [31:0] word, input int ack_delay, input logic [31:0] exp_addr);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) begin
            check("fetch_timeout", 32'd0, 32'd1);
            return;
        end
        check("imem_addr", imem_addr, exp_addr);
        for (int i = 0; i < ack_delay; i++) begin
            @(negedge clk);
            check("req_held", {31'd0, imem_req}, 32'd1);
        end
        imem_ack   = 1'b1;
        imem_rdata = word;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        check("instr_load", instr, word);
        check("exec_valid", {31'd0, instr_valid}, 32'd1);
    endtask

    task automatic do_commit(input logic [2:0] sel, input logic z, input logic [31:0] rs,
                             input logic [31:0] exp_pc, input logic exp_req);
        commit  = 1'b1;
        npc_op  = sel;
        zero    = z;
        rs_data = rs;
        @(negedge clk);
        commit  = 1'b0;
        npc_op  = 3'b000;
        zero    = 1'b0;
        rs_data = 32'd0;
        check("pc_after_commit", pc, exp_pc);
        check("req_after_commit", {31'd0, imem_req}, {31'd0, exp_req});
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        imem_ack     = 1'b0;
        imem_rdata   = 32'd0;
        commit       = 1'b0;
        npc_op       = 3'b000;
        zero         = 1'b0;
        rs_data      = 32'd0;

        // Reset and first fetch
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_pc", pc, 32'h0000_3000);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_err", {31'd0, addr_err}, 32'd0);
        check("rst_instr", instr, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("first_req", {31'd0, imem_req}, 32'd1);
        check("first_addr", imem_addr, 32'h0000_3000);
        check("first_instr", instr, 32'd0);
        check("first_pc4", pc_plus4, 32'h0000_3004);

        // Commit while fetching must be ignored
        commit = 1'b1;
        npc_op = 3'b010;
        @(negedge clk);
        commit = 1'b0;
        npc_op = 3'b000;
        check("commit_in_req_pc", pc, 32'h0000_3000);

        // beq taken with offset -1 lands back on the same pc
        fetch(32'h1000_FFFF, 0, 32'h0000_3000);
        check("op", {26'd0, op}, 32'h04);
        check("func", {26'd0, func}, 32'h3F);
        do_commit(3'b001, 1'b1, 32'd0, 32'h0000_3000, 1'b1);

        for (int i = 0; i < 4; i++) begin
            fetch(32'd0, 0, 32'h0000_3000 + 32'(4 * i));
            do_commit(3'b000, 1'b0, 32'd0, 32'h0000_3000 + 32'(4 * (i + 1)), 1'b1);
        end

        // bne taken (zero=0), then j back, then bne not taken (zero=1)
        fetch(32'h1400_0002, 0, 32'h0000_3010);
        do_commit(3'b011, 1'b0, 32'd0, 32'h0000_301C, 1'b1);
        fetch(32'h0800_0C04, 0, 32'h0000_301C);
        do_commit(3'b010, 1'b0, 32'd0, 32'h0000_3010, 1'b1);
        fetch(32'h1400_0002, 0, 32'h0000_3010);
        do_commit(3'b011, 1'b1, 32'd0, 32'h0000_3014, 1'b1);

        // beq not taken; stray ack in EXEC must not reload instr
        fetch(32'h1000_0005, 1, 32'h0000_3014);
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        check("ack_in_exec_instr", instr, 32'h1000_0005);
        do_commit(3'b001, 1'b0, 32'd0, 32'h0000_3018, 1'b1);

        // j from 0x3000 with index 0xC10
        fetch(32'h0800_0C00, 0, 32'h0000_3018);
        do_commit(3'b010, 1'b0, 32'd0, 32'h0000_3000, 1'b1);
        fetch(32'h0800_0C10, 2, 32'h0000_3000);
        do_commit(3'b010, 1'b0, 32'd0, 32'h0000_3040, 1'b1);
        check("j_pc4", pc_plus4, 32'h0000_3044);

        // Reserved select behaves sequentially; aligned jr; wrap cases
        fetch(32'd0, 0, 32'h0000_3040);
        do_commit(3'b101, 1'b1, 32'h1234_5678, 32'h0000_3044, 1'b1);
        fetch(32'd0, 0, 32'h0000_3044);
        do_commit(3'b100, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1);
        check("wrap_pc4", pc_plus4, 32'd0);
        fetch(32'd0, 0, 32'hFFFF_FFFC);
        do_commit(3'b000, 1'b0, 32'd0, 32'h0000_0000, 1'b1);
        fetch(32'h1000_FFFE, 0, 32'h0000_0000);
        do_commit(3'b001, 1'b1, 32'd0, 32'hFFFF_FFFC, 1'b1);

        // jr misaligned halts the core
        fetch(32'd0, 0, 32'hFFFF_FFFC);
        do_commit(3'b100, 1'b0, 32'h0000_3002, 32'hFFFF_FFFC, 1'b0);
        check("halt_err", {31'd0, addr_err}, 32'd1);
        check("halt_valid", {31'd0, instr_valid}, 32'd0);
        for (int i = 0; i < 12; i++) begin
            commit     = i[0];
            imem_ack   = ~i[0];
            imem_rdata = 32'hCAFE_0000;
            @(negedge clk);
            check("halt_req", {31'd0, imem_req}, 32'd0);
        end
        commit     = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        check("halt_pc", pc, 32'hFFFF_FFFC);
        check("halt_instr", instr, 32'd0);
        check("halt_err_sticky", {31'd0, addr_err}, 32'd1);

        rst = 1'b1;
        #1;
        check("clr_err", {31'd0, addr_err}, 32'd0);
        check("clr_pc", pc, 32'h0000_3000);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("clr_req", {31'd0, imem_req}, 32'd1);

        // Reset in the middle of a slow fetch; stale ack during reset/RST is ignored
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midreq_req_drop", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        imem_ack   = 1'b1;
        imem_rdata = 32'hBAD0_BAD0;
        rst        = 1'b0;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        check("stale_ack_instr", instr, 32'd0);
        check("refetch_req", {31'd0, imem_req}, 32'd1);
        fetch(32'h2000_0001, 3, 32'h0000_3000);
        do_commit(3'b000, 1'b0, 32'd0, 32'h0000_3004, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
